rh_fetch_buffer: RTL and testbench
==================================

// Module: rh_fetch_buffer
//
// PURPOSE
//  In-order instruction buffer directly downstream of the fetch unit. Captures
//  instruction-memory responses for requests the fetch unit issued (REQV/PC).
//  Presents them to the issue stage over a valid/ready handshake.
//  Throttles fetch through REQINV using credits (buffered + in-flight <= DEPTH).
//  Supports FLUSH, which discards buffered and in-flight instructions on a redirect.
//
// PARAMETERS
//  DEPTH   4   buffer entries (power of 2, >=2); also max outstanding fetch requests
//  PCW     32  PC width
//  IW      32  instruction width
//
// PORTS
//  CLK        in   1    clock, all state updates on posedge
//  RSTN       in   1    asynchronous active-low reset
//  REQV       in   1    fetch request issued this cycle (from fetch unit)
//  REQINV     out  1    request inhibit to fetch unit; 1 = no credit
//  RSPV       in   1    memory response valid
//  RSP_PC     in   PCW  PC of response
//  RSP_INSTR  in   IW   instruction word of response
//  ISSV       out  1    head entry valid toward issue stage
//  ISS_PC     out  PCW  head entry PC
//  ISS_INSTR  out  IW   head entry instruction
//  ISSRDY     in   1    issue stage accepts head entry
//  FLUSH      in   1    discard all buffered and in-flight instructions
//  ERR        out  1    sticky protocol error (unexpected response or overflow)
//
// BEHAVIOUR
//  - Reset (RSTN low, asynchronous): CNT=0, OUT=0, DROP=0, rd/wr ptr=0.
//    ISSV=0, REQINV=0, ERR=0, ISS_PC/ISS_INSTR=0. Storage is not cleared.
//  - Counters: CNT (buffered), OUT (in-flight), DROP (responses to discard).
//    All are $clog2(DEPTH+1) bits wide.
//  - REQINV = (CNT + OUT) >= DEPTH, combinational from registers.
//    REQV while REQINV=1 is ignored and sets ERR.
//  - REQV with credit: OUT+1.
//  - RSPV when DROP>0: response discarded, DROP-1.
//    Otherwise, when OUT>0: written at wr ptr, OUT-1, CNT+1.
//    Otherwise (OUT=0, DROP=0): discarded, ERR=1.
//  - REQV and a kept RSPV in the same cycle: OUT is unchanged net; CNT+1.
//  - ISSV = (CNT != 0). ISS_PC/ISS_INSTR are driven from the head entry, so
//    they are zero-latency from storage. Pop when ISSV && ISSRDY: rd ptr+1, CNT-1.
//  - Latency: a response written at edge N is visible on ISSV after edge N;
//    it can pop at edge N+1. There is no bypass, so an empty buffer adds 1 cycle.
//  - Simultaneous write and pop with CNT=DEPTH cannot occur: credit prevents it.
//    A write at CNT=DEPTH sets ERR and drops the data.
//  - Pointers are log2(DEPTH) bits and wrap naturally DEPTH-1 -> 0.
//  - FLUSH (synchronous, wins over all same-cycle events):
//    * Next-state: CNT=0, ptrs=0, OUT=0, ISSV=0.
//    * DROP <= DROP + OUT + (REQV&~REQINV) - (RSPV ? 1 : 0), saturated at 0.
//      A same-cycle REQV is stale and is dropped too.
//    * A same-cycle pop is not performed. The issue stage must ignore ISS*
//      during FLUSH.
//    * REQINV recomputes from the new CNT/OUT the next cycle, so fetch
//      resumes immediately.
//  - ERR is cleared only by reset.
//
// TESTING
//  1. Reset then REQV x4 (DEPTH=4), no RSPV -> REQINV=1 after 4th edge;
//     a 5th REQV sets ERR=1.
//  2. REQV/RSPV PC 0..3, ISSRDY=1 -> ISS_PC 0,1,2,3 in order;
//     each ISSV one cycle after its RSPV; REQINV stays 0.
//  3. Fill 4 entries with ISSRDY=0, then ISSRDY=1 while streaming 8 more ->
//     all 12 out in order; pointers wrap; CNT never >4; ERR=0.
//  4. OUT=2, CNT=1, FLUSH with REQV=1 -> next cycle ISSV=0, DROP=3;
//     next 3 RSPV dropped; 4th (new PC 0x40) is issued.
//  5. RSPV with OUT=0, DROP=0 -> ERR=1, ISSV stays 0.
//  6. Assert RSTN low mid-stream (CNT=2, OUT=1) -> ISSV, REQINV and ERR are 0
//     immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rh_fetch_buffer_if.sv
// Fetch/response/issue bundle for rh_fetch_buffer; slave is the buffer, master the environment.
// DBG_* mirror the internal occupancy counters for observation.
interface rh_fetch_buffer_if #(
  parameter int PCW = 32,
  parameter int IW  = 32,
  parameter int CW  = 3
);
  // Issue handshake: an entry moves when ISSV && ISSRDY are both high at a posedge;
  // ISSV never drops without a pop except on FLUSH or reset.
  logic           REQV;
  logic           REQINV;
  logic           RSPV;
  logic [PCW-1:0] RSP_PC;
  logic [IW-1:0]  RSP_INSTR;
  logic           ISSV;
  logic [PCW-1:0] ISS_PC;
  logic [IW-1:0]  ISS_INSTR;
  logic           ISSRDY;
  logic           FLUSH;
  logic           ERR;
  logic [CW-1:0]  DBG_CNT;
  logic [CW-1:0]  DBG_OUT;
  logic [CW-1:0]  DBG_DROP;

  modport slave (
    input  REQV, RSPV, RSP_PC, RSP_INSTR, ISSRDY, FLUSH,
    output REQINV, ISSV, ISS_PC, ISS_INSTR, ERR, DBG_CNT, DBG_OUT, DBG_DROP
  );

  modport master (
    output REQV, RSPV, RSP_PC, RSP_INSTR, ISSRDY, FLUSH,
    input  REQINV, ISSV, ISS_PC, ISS_INSTR, ERR, DBG_CNT, DBG_OUT, DBG_DROP
  );
endinterface

// File: rtl/rh_fetch_buffer.sv
// In-order instruction buffer between fetch and issue with credit-based fetch
// throttling and flush handling of in-flight responses.
module rh_fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int PCW   = 32,
  parameter int IW    = 32
) (
  input  logic               CLK,
  input  logic               RSTN,
  rh_fetch_buffer_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_W   = (CW+1)'(DEPTH);
  localparam logic [CW+1:0] DROP_MAXW = (CW+2)'({CW{1'b1}});

  logic [CW-1:0]  r_cnt, r_out, r_drop;
  logic [AW-1:0]  r_rd, r_wr;
  logic           r_err;
  logic [PCW-1:0] r_pc_mem    [DEPTH];
  logic [IW-1:0]  r_instr_mem [DEPTH];

  logic [CW:0]    w_used;
  logic           w_reqinv, w_req, w_req_err;
  logic           w_rsp_drop, w_rsp_keep, w_rsp_err;
  logic           w_full, w_wr, w_ovf;
  logic           w_issv, w_pop;
  logic [CW+1:0]  w_drop_sum, w_drop_dec;
  logic [CW-1:0]  w_drop_flush;

  assign w_used     = {1'b0, r_cnt} + {1'b0, r_out};
  assign w_reqinv   = (w_used >= DEPTH_W);
  assign w_req      = bus.REQV & ~w_reqinv;
  assign w_req_err  = bus.REQV & w_reqinv;

  assign w_rsp_drop = bus.RSPV & (r_drop != '0);
  assign w_rsp_keep = bus.RSPV & (r_drop == '0) & (r_out != '0);
  assign w_rsp_err  = bus.RSPV & (r_drop == '0) & (r_out == '0);

  assign w_full     = (r_cnt == DEPTH_C);
  assign w_wr       = w_rsp_keep & ~w_full;
  assign w_ovf      = w_rsp_keep & w_full;

  assign w_issv     = (r_cnt != '0);
  assign w_pop      = w_issv & bus.ISSRDY & ~bus.FLUSH;

  // Everything still owed by memory becomes a response to discard; clamp both ends.
  assign w_drop_sum = {2'b00, r_drop} + {2'b00, r_out} + (CW+2)'(w_req);
  assign w_drop_dec = (w_drop_sum > (CW+2)'(bus.RSPV)) ? (w_drop_sum - (CW+2)'(bus.RSPV)) : '0;
  assign w_drop_flush = (w_drop_dec > DROP_MAXW) ? {CW{1'b1}} : w_drop_dec[CW-1:0];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_cnt  <= '0;
      r_out  <= '0;
      r_drop <= '0;
      r_rd   <= '0;
      r_wr   <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_req_err | ((w_rsp_err | w_ovf) & ~bus.FLUSH)) r_err <= 1'b1;
      if (bus.FLUSH) begin
        r_cnt  <= '0;
        r_out  <= '0;
        r_rd   <= '0;
        r_wr   <= '0;
        r_drop <= w_drop_flush;
      end else begin
        if (w_wr)  r_wr <= r_wr + AW'(1);
        if (w_pop) r_rd <= r_rd + AW'(1);
        r_cnt <= r_cnt + CW'(w_wr) - CW'(w_pop);
        r_out <= r_out + CW'(w_req) - CW'(w_rsp_keep);
        if (w_rsp_drop) r_drop <= r_drop - CW'(1);
      end
    end
  end

  // Storage is intentionally not reset; validity is tracked by r_cnt.
  always_ff @(posedge CLK) begin
    if (w_wr && !bus.FLUSH) begin
      r_pc_mem[r_wr]    <= bus.RSP_PC;
      r_instr_mem[r_wr] <= bus.RSP_INSTR;
    end
  end

  assign bus.REQINV    = w_reqinv;
  assign bus.ISSV      = w_issv;
  assign bus.ISS_PC    = w_issv ? r_pc_mem[r_rd]    : '0;
  assign bus.ISS_INSTR = w_issv ? r_instr_mem[r_rd] : '0;
  assign bus.ERR       = r_err;
  assign bus.DBG_CNT   = r_cnt;
  assign bus.DBG_OUT   = r_out;
  assign bus.DBG_DROP  = r_drop;
endmodule

// File: tb/tb_rh_fetch_buffer.sv
// Directed bench for rh_fetch_buffer: a vector table for single-cycle behaviour plus
// hand-written sequences for streaming, flush and asynchronous reset.
module tb_rh_fetch_buffer;
  localparam int DEPTH = 4;
  localparam int PCW   = 32;
  localparam int IW    = 32;
  localparam int CW    = 3;

  logic CLK;
  logic RSTN;
  int   checks;
  int   errors;

  rh_fetch_buffer_if #(.PCW(PCW), .IW(IW), .CW(CW)) bus ();

  rh_fetch_buffer #(.DEPTH(DEPTH), .PCW(PCW), .IW(IW)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        pre_rst;
    logic        reqv;
    logic        rspv;
    logic [31:0] pc;
    logic        issrdy;
    logic        flush;
    logic        e_issv;
    logic [31:0] e_pc;
    logic        e_reqinv;
    logic        e_err;
  } vec_t;

  vec_t vecs [13];
  logic [PCW-1:0] req_q [$];
  logic [PCW-1:0] exp_q [$];

  function automatic logic [IW-1:0] mk_instr(input logic [PCW-1:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  function automatic vec_t mk(input logic pr, input logic rq, input logic rs, input logic [31:0] pc,
                              input logic rdy, input logic fl, input logic ev,
                              input logic [31:0] ep, input logic ei, input logic ee);
    vec_t v;
    v.pre_rst = pr; v.reqv = rq; v.rspv = rs; v.pc = pc; v.issrdy = rdy; v.flush = fl;
    v.e_issv = ev; v.e_pc = ep; v.e_reqinv = ei; v.e_err = ee;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rq, input logic rs, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    bus.REQV      = rq;
    bus.RSPV      = rs;
    bus.RSP_PC    = pc;
    bus.RSP_INSTR = mk_instr(pc);
    bus.ISSRDY    = rdy;
    bus.FLUSH     = fl;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    RSTN = 1'b0;
    tick();
    RSTN = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int sent, got, cyc, max_cnt;

  initial begin
    checks = 0;
    errors = 0;
    RSTN   = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    do_reset();

    check("rst_issv",   32'(bus.ISSV),      32'd0);
    check("rst_reqinv", 32'(bus.REQINV),    32'd0);
    check("rst_err",    32'(bus.ERR),       32'd0);
    check("rst_pc",     bus.ISS_PC,         32'd0);
    check("rst_instr",  bus.ISS_INSTR,      32'd0);
    check("rst_cnt",    32'(bus.DBG_CNT),   32'd0);
    check("rst_out",    32'(bus.DBG_OUT),   32'd0);
    check("rst_drop",   32'(bus.DBG_DROP),  32'd0);

    // credit exhaustion, in-order pass-through, unexpected response
    vecs[0]  = mk(1, 1, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0);
    vecs[2]  = mk(0, 1, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0);
    vecs[3]  = mk(0, 1, 0, 32'h0, 0, 0, 0, 32'h0, 1, 0);
    vecs[4]  = mk(0, 1, 0, 32'h0, 0, 0, 0, 32'h0, 1, 1);
    vecs[5]  = mk(1, 1, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0);
    vecs[6]  = mk(0, 1, 1, 32'h0, 1, 0, 1, 32'h0, 0, 0);
    vecs[7]  = mk(0, 1, 1, 32'h1, 1, 0, 1, 32'h1, 0, 0);
    vecs[8]  = mk(0, 1, 1, 32'h2, 1, 0, 1, 32'h2, 0, 0);
    vecs[9]  = mk(0, 0, 1, 32'h3, 1, 0, 1, 32'h3, 0, 0);
    vecs[10] = mk(0, 0, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0);
    vecs[11] = mk(1, 0, 1, 32'h99, 0, 0, 0, 32'h0, 0, 1);
    vecs[12] = mk(0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 1);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].pre_rst) do_reset();
      drive(vecs[i].reqv, vecs[i].rspv, vecs[i].pc, vecs[i].issrdy, vecs[i].flush);
      tick();
      check($sformatf("v%0d_issv", i),   32'(bus.ISSV),   32'(vecs[i].e_issv));
      check($sformatf("v%0d_reqinv", i), 32'(bus.REQINV), 32'(vecs[i].e_reqinv));
      check($sformatf("v%0d_err", i),    32'(bus.ERR),    32'(vecs[i].e_err));
      if (vecs[i].e_issv) begin
        check($sformatf("v%0d_pc", i),    bus.ISS_PC,    vecs[i].e_pc);
        check($sformatf("v%0d_instr", i), bus.ISS_INSTR, mk_instr(vecs[i].e_pc));
      end
    end

    // fill with issue stalled, then stream 8 more through with wrap-around
    do_reset();
    sent = 0; got = 0; max_cnt = 0;
    req_q.delete(); exp_q.delete();
    for (cyc = 0; cyc < 50; cyc++) begin
      if (bus.DBG_CNT == 3'd4) break;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      if (req_q.size() > 0) begin
        logic [PCW-1:0] p;
        p = req_q.pop_front();
        drive(1'b0, 1'b1, p, 1'b0, 1'b0);
        exp_q.push_back(p);
      end
      if (sent < 4 && !bus.REQINV) begin
        bus.REQV = 1'b1;
        req_q.push_back(32'(sent * 4));
        sent++;
      end
      tick();
    end
    check("fill_cnt",    32'(bus.DBG_CNT), 32'd4);
    check("fill_reqinv", 32'(bus.REQINV),  32'd1);
    check("fill_issv",   32'(bus.ISSV),    32'd1);
    for (cyc = 0; cyc < 200; cyc++) begin
      if (got == 12) break;
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      if (32'(bus.DBG_CNT) > max_cnt) max_cnt = 32'(bus.DBG_CNT);
      if (bus.ISSV) begin
        if (exp_q.size() == 0) begin
          check("stream_extra_issv", 32'd1, 32'd0);
        end else begin
          logic [PCW-1:0] e;
          e = exp_q.pop_front();
          check($sformatf("stream_pc%0d", got),    bus.ISS_PC,    e);
          check($sformatf("stream_instr%0d", got), bus.ISS_INSTR, mk_instr(e));
        end
        got++;
      end
      if (req_q.size() > 0) begin
        logic [PCW-1:0] p;
        p = req_q.pop_front();
        bus.RSPV = 1'b1; bus.RSP_PC = p; bus.RSP_INSTR = mk_instr(p);
        exp_q.push_back(p);
      end
      if (sent < 12 && !bus.REQINV) begin
        bus.REQV = 1'b1;
        req_q.push_back(32'(sent * 4));
        sent++;
      end
      tick();
    end
    check("stream_count", 32'(got), 32'd12);
    check("stream_maxcnt_le4", 32'(max_cnt <= 4), 32'd1);
    check("stream_err", 32'(bus.ERR), 32'd0);

    // flush with two in flight, one buffered, and a same-cycle request
    do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    tick();
    tick();
    drive(1'b0, 1'b1, 32'h10, 1'b0, 1'b0); tick();
    check("fl_pre_cnt", 32'(bus.DBG_CNT), 32'd1);
    check("fl_pre_out", 32'(bus.DBG_OUT), 32'd2);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1); tick();
    check("fl_issv",   32'(bus.ISSV),     32'd0);
    check("fl_drop",   32'(bus.DBG_DROP), 32'd3);
    check("fl_out",    32'(bus.DBG_OUT),  32'd0);
    check("fl_reqinv", 32'(bus.REQINV),   32'd0);
    drive(1'b1, 1'b1, 32'h14, 1'b1, 1'b0); tick();
    check("fl_d1_issv", 32'(bus.ISSV), 32'd0);
    drive(1'b0, 1'b1, 32'h18, 1'b1, 1'b0); tick();
    check("fl_d2_issv", 32'(bus.ISSV), 32'd0);
    drive(1'b0, 1'b1, 32'h1C, 1'b1, 1'b0); tick();
    check("fl_d3_issv", 32'(bus.ISSV),     32'd0);
    check("fl_d3_drop", 32'(bus.DBG_DROP), 32'd0);
    drive(1'b0, 1'b1, 32'h40, 1'b0, 1'b0); tick();
    check("fl_new_issv", 32'(bus.ISSV), 32'd1);
    check("fl_new_pc",   bus.ISS_PC,    32'h40);
    check("fl_err",      32'(bus.ERR),  32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0); tick();
    check("fl_pop_issv", 32'(bus.ISSV), 32'd0);

    // asynchronous reset in the middle of activity, with ERR set
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    end
    drive(1'b0, 1'b1, 32'h100, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 32'h104, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b1, 32'h108, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("ar_pre_cnt",  32'(bus.DBG_CNT), 32'd2);
    check("ar_pre_out",  32'(bus.DBG_OUT), 32'd1);
    check("ar_pre_err",  32'(bus.ERR),     32'd1);
    check("ar_pre_pc",   bus.ISS_PC,       32'h104);
    #2;
    RSTN = 1'b0;
    #1;
    check("ar_issv",   32'(bus.ISSV),   32'd0);
    check("ar_reqinv", 32'(bus.REQINV), 32'd0);
    check("ar_err",    32'(bus.ERR),    32'd0);
    check("ar_pc",     bus.ISS_PC,      32'd0);
    RSTN = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
